// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Brief    : Immediate extension (zero/sign/upper/branch) registered behind a
//            2-entry skid FIFO with valid/ready on both sides, a sideband tag
//            and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int         c_PAD_W      = OUT_W - IN_W;
    localparam logic [1:0] c_MODE_ZERO  = 2'b00;
    localparam logic [1:0] c_MODE_SIGN  = 2'b01;
    localparam logic [1:0] c_MODE_UPPER = 2'b10;
    localparam logic [1:0] c_MODE_BRANCH = 2'b11;
    localparam logic [1:0] c_FULL       = 2'd2;

    logic [OUT_W-1:0] imm_mem_q [2];
    logic [TAG_W-1:0] tag_mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q,  count_d;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_pop;

    assign w_sext = {{c_PAD_W{in_imm[IN_W-1]}}, in_imm};

    // Extension selected by mode; computed before the buffer so only the result is stored.
    always_comb begin
        w_ext = '0;
        case (in_mode)
            c_MODE_ZERO:   w_ext = {{c_PAD_W{1'b0}}, in_imm};
            c_MODE_SIGN:   w_ext = w_sext;
            c_MODE_UPPER:  w_ext = {in_imm, {c_PAD_W{1'b0}}};
            c_MODE_BRANCH: w_ext = {w_sext[OUT_W-3:0], 2'b00};
            default:       w_ext = '0;
        endcase
    end

    // in_ready derives only from stored occupancy, never from out_ready.
    assign in_ready  = (count_q != c_FULL);
    assign out_valid = (count_q != 2'd0);
    assign out_imm   = imm_mem_q[rd_ptr_q];
    assign out_tag   = tag_mem_q[rd_ptr_q];

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // Pointer and occupancy next state; flush wins over any accept or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_accept) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_accept, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears entries so out_imm/out_tag read zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                imm_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (!flush && w_accept) begin
                imm_mem_q[wr_ptr_q] <= w_ext;
                tag_mem_q[wr_ptr_q] <= in_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension stage for the decode path of the MIPS core. It accepts an IN_W-bit immediate plus a mode, producing an OUT_W-bit value as zero-extended, sign-extended, upper-placed (LUI) or sign-extended-and-shifted-by-2 (branch offset). The result is registered behind a 2-entry skid buffer with valid/ready handshake on both sides, so decode can stall without losing an immediate. A tag travels with each immediate, and a synchronous flush discards in-flight entries on a branch or exception.

## Interface
- IN_W, 16, immediate input width; legal range is 1 to OUT_W-2.
- OUT_W, 32, extended output width.
- TAG_W, 5, sideband tag width (for example, the destination register); legal minimum is 1.
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; empties the buffer.
- in_valid  input  1  input holds a valid immediate.
- in_ready  output  1  stage can accept this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode:
  - 00 zero-extend.
  - 01 sign-extend.
  - 10 upper.
  - 11 branch.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- out_valid  output  1  out_imm and out_tag are valid.
- out_ready  input  1  consumer accepts this cycle.
- out_imm  output  OUT_W  extended result.
- out_tag  output  TAG_W  tag paired with out_imm.

## Operation
- Extension is combinational on the input side; the result is written into the buffer at acceptance.
  - 00: {(OUT_W-IN_W) zeros, in_imm}.
  - 01: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - 10: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], with zeros below.
  - 11: the sign-extended value with its top 2 bits dropped, followed by 2'b00. Equivalently, (sext << 2) truncated to OUT_W.
- Buffer: 2 entries, FIFO order, with read pointer, write pointer and count (0..2). Pointers wrap modulo 2.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count != 2). It is registered state and does not combinationally depend on out_ready.
- out_valid = (count != 0). out_imm and out_tag always come from the read-pointer entry.
- Simultaneous accept and pop:
  - count 1: count stays 1; the entry moves forward in order.
  - count 2: no accept is possible because in_ready is 0.
- Flush, synchronous:
  - Next cycle: count = 0, both pointers = 0, out_valid = 0, in_ready = 1.
  - An accept or pop in the flush cycle is discarded.
  - Flush overrides any accept or pop in the same cycle.
- An undriven or illegal in_mode cannot occur, since all four codes are defined.

## Timing
- Latency is 1 cycle: an immediate accepted at edge N is visible on out_* after edge N and is poppable in cycle N+1 at the earliest.
- Throughput is 1 per cycle while out_ready is held high. No bubbles at count 1 with accept and pop in the same cycle.
- Backpressure:
  - With out_ready low, two more immediates are absorbed.
  - in_ready then drops in the cycle after the second accept.
  - in_ready returns to 1 in the cycle after the first pop.
- Holding rule: while out_valid && !out_ready, out_imm and out_tag are stable.
- Reset while resetn is low:
  - count = 0 and pointers = 0.
  - out_valid = 0, in_ready = 1.
  - out_imm = 0, out_tag = 0, and all buffer entries = 0.
- Reset mid-operation drops all entries immediately, asynchronously. The first accept is possible on the first rising edge after resetn deasserts.

## Test plan
- Modes, IN_W=16, OUT_W=32, imm 16'h8004:
  - Mode 00 -> 32'h0000_8004.
  - Mode 01 -> 32'hFFFF_8004.
  - Mode 10 -> 32'h8004_0000.
  - Mode 11 -> 32'hFFFE_0010.
  - Imm 16'h7FFF in mode 01 -> 32'h0000_7FFF.
- Streaming: 8 back-to-back accepts with out_ready=1, tags 0..7 -> out_valid is high for 8 consecutive cycles starting 1 cycle after the first accept, with tags in order and in_ready never low.
- Backpressure: out_ready=0 and 3 offered immediates A, B, C ->
  - A and B are accepted, then in_ready=0 and C is held.
  - After raising out_ready, the outputs are A, B, C in order.
  - out_imm is stable while stalled.
- Flush: count=2 and flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, and no entry or pop takes effect.
- Reset mid-stream: resetn pulsed low with count=1 -> out_valid falls immediately and out_imm reads 0. The first accept after release appears 1 cycle later.
- Parameter sweep at IN_W=8, OUT_W=16, imm 8'h81:
  - Mode 01 -> 16'hFF81.
  - Mode 10 -> 16'h8100.
  - Mode 11 -> 16'hFE04.
